// File: rtl/fifo_sync_if.sv
// fifo_sync_if: handshake/status bundle between a producer/consumer and fifo_sync.
//   data_in, push, pop      : driven by the master (producer/consumer side)
//   data_out, valid         : registered read data and its one-cycle qualifier
//   count                   : occupancy 0..DEPTH
//   full, empty             : occupancy decodes
//   almost_full/almost_empty: threshold decodes of occupancy
//   overflow, underflow     : sticky error flags
interface fifo_sync_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, push, pop,
        input  data_out, valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  data_in, push, pop,
        output data_out, valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: parametrised single-clock FIFO with registered read data.
//   clk  : rising-edge clock for all state
//   rst  : synchronous active-high reset (clears pointers, count, read
//          register and error flags; storage array is left as-is)
//   bus  : fifo_sync_if slave port carrying data_in/push/pop in and
//          data_out/valid/count/status/error flags out
// The bus interface must be instantiated with the same WIDTH/DEPTH.
module fifo_sync #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input logic         clk,
    input logic         rst,
    fifo_sync_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             full_c;
    logic             empty_c;
    logic             pop_ok;
    logic             push_ok;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

    // A pop frees a slot in the same edge, so a full FIFO can still take a
    // push when it is popped. An empty FIFO never returns the incoming word.
    assign pop_ok  = bus.pop & ~empty_c;
    assign push_ok = bus.push & (~full_c | pop_ok);

    // Storage has no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                data_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus.push && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (bus.pop && !pop_ok) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.data_out     = data_q;
    assign bus.valid        = valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed plus short random stimulus against fifo_sync
// (WIDTH=4, DEPTH=4) with a queue-based reference and output scoreboard.
module tb_fifo_sync;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int AF = D - 1;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_sync_if #(.WIDTH(W), .DEPTH(D)) bus ();

    fifo_sync #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mdl[$];
    logic [W-1:0] expq[$];
    logic [W-1:0] last_data = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf   = 1'b0;
    logic         m_udf   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mdl.size();
        chk("count",        32'(bus.count),        32'(n));
        chk("full",         32'(bus.full),         32'(n == D));
        chk("empty",        32'(bus.empty),        32'(n == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_udf));
        chk("valid",        32'(bus.valid),        32'(m_valid));
        chk("data_out",     32'(bus.data_out),     32'(last_data));
        if (bus.valid && expq.size() > 0) begin
            chk("sb_data", 32'(bus.data_out), 32'(expq.pop_front()));
        end
    endtask

    // One clock of stimulus; the reference is updated from pre-edge state.
    task automatic step(input logic p, input logic q, input logic [W-1:0] d);
        logic pop_ok, push_ok;
        @(negedge clk);
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        pop_ok  = q && (mdl.size() > 0);
        push_ok = p && ((mdl.size() < D) || pop_ok);
        m_valid = pop_ok;
        if (pop_ok) begin
            last_data = mdl.pop_front();
            expq.push_back(last_data);
        end
        if (push_ok) mdl.push_back(d);
        if (p && !push_ok) m_ovf = 1'b1;
        if (q && !pop_ok)  m_udf = 1'b1;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        check_all();
    endtask

    // Reset with optional push/pop asserted to confirm rst has priority.
    task automatic do_reset(input logic p, input logic q);
        @(negedge clk);
        rst         = 1'b1;
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = 4'hE;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        mdl.delete();
        expq.delete();
        last_data = '0;
        m_valid   = 1'b0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
        check_all();
    endtask

    initial begin
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;

        // Reset then idle
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0);

        // Fill 1..4 then drain
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 4'(i));
        for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0);

        // Overflow on full, then drain
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 4'(i));
        step(1'b1, 1'b0, 4'h9);
        for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0);

        // Underflow, push+pop on empty, then pop the pushed word
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h5);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0);

        // Push+pop on full keeps count; drain exercises wrap
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 4'(i));
        step(1'b1, 1'b1, 4'hA);
        for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0);

        // Reset mid-operation discards contents; rst beats a push
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 4'(i));
        do_reset(1'b1, 1'b1);
        step(1'b1, 1'b0, 4'h7);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0);

        // Random sustained traffic
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h0);

        chk("sb_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_sync.md
# fifo_sync

Parametrised synchronous FIFO replacing the earlier unclocked 4x4 push/pop buffer. It stores up to DEPTH words of WIDTH bits and gives registered first-in-first-out read data. It provides occupancy, full/empty and almost-full/almost-empty status, plus sticky overflow/underflow error flags. It sits between producer and consumer logic in the same clock domain and is the standard buffering primitive for the datapath.

## Interface
- WIDTH, 4: data word width in bits (>=1).
- DEPTH, 4: number of storage entries; power of two, >=2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  write data, sampled on an accepted push.
- push  input  1  write request.
- pop  input  1  read request.
- data_out  output  WIDTH  registered read data.
- valid  output  1  high for exactly one cycle after an accepted pop; data_out is valid in that cycle.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- overflow  output  1  sticky; set by a rejected push.
- underflow  output  1  sticky; set by a rejected pop.

## Operation
- Storage is a DEPTH x WIDTH array with a write pointer and a read pointer, each $clog2(DEPTH) bits. Both pointers wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate count register.
- Accept rules, all evaluated from the state before the clock edge:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok).
- A push to a full FIFO is accepted only when a pop is accepted in the same cycle.
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted pop: data_out <= mem[rd_ptr]; rd_ptr increments; valid <= 1.
- If no pop is accepted, valid <= 0 and data_out holds its last value.
- Count update: +1 for push_ok only; -1 for pop_ok only; unchanged when both or neither are accepted.
- Simultaneous push and pop on an empty FIFO: the pop is rejected and underflow is set. The push is accepted and count becomes 1. There is no fall-through: the pop does not return the word being written.
- Rejected push (push & full & !pop_ok): nothing is written, pointers are unchanged, overflow <= 1.
- Rejected pop (pop & empty): the read pointer and data_out are unchanged, valid <= 0, underflow <= 1.
- overflow and underflow stay set until rst.
- full, empty, almost_full and almost_empty are combinational decodes of the count register, so they are registered-equivalent and glitch-free relative to clk.

## Timing
- Reset (rst high at a rising edge) forces: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid=0, overflow=0, underflow=0.
- Resulting status after reset: empty=1, full=0, almost_empty=1, and almost_full=0 (AF_LEVEL>=1).
- Memory contents are not reset.
- rst has priority over push and pop in the same cycle. A reset mid-operation discards all stored words.
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1. It appears on data_out, with valid=1, after edge N+1.
- Pop latency: data_out and valid update one cycle after the accepted pop request.
- Status latency: count and all flags reflect a push or pop one cycle after the edge that accepted it.
- Throughput: one push and one pop per cycle, sustained, at any occupancy except the empty-pop case above.

## Test plan
- Reset then idle (WIDTH=4, DEPTH=4). Required: count=0, empty=1, full=0, almost_empty=1, data_out=0, valid=0, overflow=0, underflow=0.
- Push 0x1,0x2,0x3,0x4 on consecutive cycles, then pop 4 cycles:
  - Fill: full=1 and count=4 after the 4th push; almost_full=1 from count=3.
  - Drain: data_out reads 0x1,0x2,0x3,0x4, each with valid=1; empty=1 at the end.
- Fill to 4, then push 0x9 with pop=0. Required: 0x9 is dropped and overflow=1. Drain returns 0x1..0x4 only; overflow stays 1.
- Pop while empty. Required: underflow=1, valid=0, data_out unchanged. Then push 0x5 together with pop: count=1, underflow stays 1; the next pop returns 0x5.
- Full FIFO, push 0xA with pop in the same cycle. Required: count stays 4, data_out=0x1, no overflow. The subsequent drain returns 0x2,0x3,0x4,0xA, which exercises pointer wrap-around.
- Fill to 3, then assert rst. Required: all outputs return to reset values. Push 0x7 then pop returns 0x7, with no stale data.
